// File: rtl/ysyx_041514_bpu_resolve_pkg.sv
// ysyx_041514_bpu_resolve_pkg -- shared system configuration for the BPU
// resolve slice.
//
// This file is the common definitions point. The global macros (XLEN, RAS depth,
// and the CTRLBUS stage indices) are defined once here under an include guard.
// The package then turns them into typed constants: the redirect FSM encoding
// and the flush mask that a redirect raises.
//
// Optional feature macro used elsewhere in the slice: YSYX_041514_BPU_STATS_EN.
// When it is defined, the top adds 64-bit resolve and mispredict counters.

`ifndef YSYX_041514_SYSCONFIG
`define YSYX_041514_SYSCONFIG
`define ysyx_041514_XLEN            64
`define ysyx_041514_BPU_CAS_NUM     16
`define ysyx_041514_CTRLBUS_W       6
`define ysyx_041514_CTRLBUS_PC      0
`define ysyx_041514_CTRLBUS_IF_ID   1
`define ysyx_041514_CTRLBUS_ID_EX   2
`define ysyx_041514_CTRLBUS_EX_MEM  3
`define ysyx_041514_CTRLBUS_MEM_WB  4
`define ysyx_041514_CTRLBUS_WB      5
`endif

package ysyx_041514_bpu_resolve_pkg;

  localparam int XLEN      = `ysyx_041514_XLEN;
  localparam int CTRLBUS_W = `ysyx_041514_CTRLBUS_W;

  // Redirect FSM: IDLE watches EX, REDIR holds a redirect until the PC stage
  // takes it.
  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } bpu_state_e;

  // Returns a one-hot CTRLBUS vector for a stage index.
  function automatic logic [CTRLBUS_W-1:0] ctrl_bit(input int idx);
    return CTRLBUS_W'(1) << idx;
  endfunction

  // A redirect kills everything younger than EX: the PC register and the
  // IF/ID and ID/EX latches.
  localparam logic [CTRLBUS_W-1:0] REDIR_FLUSH_MASK =
    ctrl_bit(`ysyx_041514_CTRLBUS_PC) |
    ctrl_bit(`ysyx_041514_CTRLBUS_IF_ID) |
    ctrl_bit(`ysyx_041514_CTRLBUS_ID_EX);

endpackage

// File: rtl/ysyx_041514_bpu_resolve_if.sv
// ysyx_041514_bpu_resolve_if -- EX-stage control-flow resolve bundle.
//
// This bundle carries the outcome of the EX instruction together with the
// prediction that fetch made for it.
//   ex_valid    : EX holds a valid instruction
//   ex_is_cf    : instruction is a branch, jal or jalr
//   ex_taken    : resolved direction
//   ex_target   : resolved target
//   ex_pc       : PC of the EX instruction
//   pred_valid  : fetch predicted taken
//   pred_target : target that fetch predicted
// Modports: master drives the bundle and slave consumes it. The compare unit
// is the slave.

interface ysyx_041514_bpu_resolve_if;
  import ysyx_041514_bpu_resolve_pkg::*;

  logic            ex_valid;
  logic            ex_is_cf;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_pc;
  logic            pred_valid;
  logic [XLEN-1:0] pred_target;

  modport master (
    output ex_valid, ex_is_cf, ex_taken, ex_target, ex_pc, pred_valid, pred_target
  );

  modport slave (
    input ex_valid, ex_is_cf, ex_taken, ex_target, ex_pc, pred_valid, pred_target
  );

endinterface

// File: rtl/ysyx_041514_bpu_cmp.sv
// ysyx_041514_bpu_cmp -- combinational resolve/compare unit.
//
// This unit decides whether the EX control-flow instruction was predicted
// correctly, and it produces the PC that fetch should have followed.
// Ports:
//   bus          : resolve bundle (slave modport)
//   stall_id_ex  : ID_EX stall bit; a stalled EX slot does not resolve
//   resolve      : a control-flow instruction resolves this cycle
//   mispredict   : the resolve disagrees with the prediction
//   correct_pc   : resolved target when taken, otherwise pc+4 (wraps)

module ysyx_041514_bpu_cmp
  import ysyx_041514_bpu_resolve_pkg::*;
(
  ysyx_041514_bpu_resolve_if.slave bus,
  input  logic            stall_id_ex,
  output logic            resolve,
  output logic            mispredict,
  output logic [XLEN-1:0] correct_pc
);

  logic target_hit;

  assign resolve    = bus.ex_valid & bus.ex_is_cf & ~stall_id_ex;
  assign target_hit = (bus.pred_target == bus.ex_target);

  // Taken mispredict: fetch did not predict taken, or it went to the wrong place.
  // Not-taken mispredict: fetch predicted taken.
  assign mispredict = resolve &
                      (( bus.ex_taken & (~bus.pred_valid | ~target_hit)) |
                       (~bus.ex_taken &   bus.pred_valid));

  assign correct_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));

endmodule

// File: rtl/ysyx_041514_bpu_resolve.sv
// ysyx_041514_bpu_resolve -- branch resolve and redirect controller.
//
// This block watches EX-stage control flow. On a mispredict it registers the
// correct PC and the RAS checkpoint. It then holds a redirect toward the PC
// stage until that stage accepts it. While the redirect is outstanding it
// flushes PC, IF_ID and ID_EX.
// Ports:
//   clk, rst (sync, active low)
//   stall_valid_i        : per-stage stall vector (CTRLBUS order)
//   ex_* / pred_*        : EX instruction outcome and its prediction
//   ex_ras_ptr_i         : RAS top pointer checkpoint for the EX instruction
//   redirect_ready_i     : PC stage accepts the redirect
//   redirect_valid_o/pc_o/ras_ptr_o/ras_ptr_valid_o : redirect request
//   flush_valid_o        : flush vector (CTRLBUS order)
//   cf_cnt_o, mispred_cnt_o : only with YSYX_041514_BPU_STATS_EN defined

module ysyx_041514_bpu_resolve
  import ysyx_041514_bpu_resolve_pkg::*;
#(
  parameter int RAS_PTR_W = $clog2(`ysyx_041514_BPU_CAS_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTRLBUS_W-1:0] stall_valid_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_is_cf_i,
  input  logic                 ex_taken_i,
  input  logic [XLEN-1:0]      ex_target_i,
  input  logic [XLEN-1:0]      ex_pc_i,
  input  logic                 pred_valid_i,
  input  logic [XLEN-1:0]      pred_target_i,
  input  logic [RAS_PTR_W-1:0] ex_ras_ptr_i,
  input  logic                 redirect_ready_i,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic [RAS_PTR_W-1:0] redirect_ras_ptr_o,
  output logic                 redirect_ras_ptr_valid_o,
`ifdef YSYX_041514_BPU_STATS_EN
  output logic [63:0]          cf_cnt_o,
  output logic [63:0]          mispred_cnt_o,
`endif
  output logic [CTRLBUS_W-1:0] flush_valid_o
);

  ysyx_041514_bpu_resolve_if ex_bus ();

  assign ex_bus.ex_valid    = ex_valid_i;
  assign ex_bus.ex_is_cf    = ex_is_cf_i;
  assign ex_bus.ex_taken    = ex_taken_i;
  assign ex_bus.ex_target   = ex_target_i;
  assign ex_bus.ex_pc       = ex_pc_i;
  assign ex_bus.pred_valid  = pred_valid_i;
  assign ex_bus.pred_target = pred_target_i;

  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;

  ysyx_041514_bpu_cmp u_cmp (
    .bus         (ex_bus.slave),
    .stall_id_ex (stall_valid_i[`ysyx_041514_CTRLBUS_ID_EX]),
    .resolve     (resolve),
    .mispredict  (mispredict),
    .correct_pc  (correct_pc)
  );

  // Only the ID_EX stall bit gates resolution.
  logic unused_stall;
  assign unused_stall = ^(stall_valid_i & ~ctrl_bit(`ysyx_041514_CTRLBUS_ID_EX));

  bpu_state_e           state_q, state_d;
  logic [XLEN-1:0]      pc_q;
  logic [RAS_PTR_W-1:0] ras_ptr_q;
  logic                 first_q;
  logic                 capture;

  // Mispredicts are only accepted in IDLE. In REDIR the EX slot holds
  // wrong-path instructions.
  assign capture = (state_q == IDLE) & mispredict;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ras_ptr_q <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= capture;
      if (capture) begin
        pc_q      <= correct_pc;
        ras_ptr_q <= ex_ras_ptr_i;
      end
    end
  end

  always_comb begin
    state_d                  = state_q;
    redirect_valid_o         = 1'b0;
    redirect_pc_o            = '0;
    redirect_ras_ptr_o       = '0;
    redirect_ras_ptr_valid_o = 1'b0;
    flush_valid_o            = '0;
    unique case (state_q)
      IDLE: begin
        if (mispredict) state_d = REDIR;
      end
      REDIR: begin
        redirect_valid_o         = 1'b1;
        redirect_pc_o            = pc_q;
        redirect_ras_ptr_o       = ras_ptr_q;
        // The RAS restore fires once, in the first cycle of the redirect.
        redirect_ras_ptr_valid_o = first_q;
        flush_valid_o            = REDIR_FLUSH_MASK;
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef YSYX_041514_BPU_STATS_EN
  logic [63:0] cf_cnt_q, mispred_cnt_q;

  // The counters include only resolves seen in IDLE, so wrong-path
  // instructions are not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cf_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && resolve) cf_cnt_q <= cf_cnt_q + 64'd1;
      if (capture) mispred_cnt_q <= mispred_cnt_q + 64'd1;
    end
  end

  assign cf_cnt_o      = cf_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  logic unused_resolve;
  assign unused_resolve = resolve;
`endif

endmodule

// File: tb/tb_ysyx_041514_bpu_resolve.sv
// tb_ysyx_041514_bpu_resolve -- self-checking bench for the resolve block.
// Inputs change on the falling edge. Each expected output record is queued
// when its stimulus is driven, and it is popped and compared one falling
// edge later, after the rising edge that consumes the stimulus.

module tb_ysyx_041514_bpu_resolve;
  import ysyx_041514_bpu_resolve_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [5:0]           stall_valid;
  logic [3:0]           ex_ras_ptr;
  logic                 redirect_ready;
  logic                 redirect_valid;
  logic [63:0]          redirect_pc;
  logic [3:0]           redirect_ras_ptr;
  logic                 redirect_ras_ptr_valid;
  logic [5:0]           flush_valid;
`ifdef YSYX_041514_BPU_STATS_EN
  logic [63:0]          cf_cnt;
  logic [63:0]          mispred_cnt;
`endif

  ysyx_041514_bpu_resolve_if exb ();

  always #5 clk = ~clk;

  ysyx_041514_bpu_resolve dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_valid_i            (stall_valid),
    .ex_valid_i               (exb.ex_valid),
    .ex_is_cf_i               (exb.ex_is_cf),
    .ex_taken_i               (exb.ex_taken),
    .ex_target_i              (exb.ex_target),
    .ex_pc_i                  (exb.ex_pc),
    .pred_valid_i             (exb.pred_valid),
    .pred_target_i            (exb.pred_target),
    .ex_ras_ptr_i             (ex_ras_ptr),
    .redirect_ready_i         (redirect_ready),
    .redirect_valid_o         (redirect_valid),
    .redirect_pc_o            (redirect_pc),
    .redirect_ras_ptr_o       (redirect_ras_ptr),
    .redirect_ras_ptr_valid_o (redirect_ras_ptr_valid),
`ifdef YSYX_041514_BPU_STATS_EN
    .cf_cnt_o                 (cf_cnt),
    .mispred_cnt_o            (mispred_cnt),
`endif
    .flush_valid_o            (flush_valid)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  stall;
    logic        valid;
    logic        is_cf;
    logic        taken;
    logic [63:0] pc;
    logic [63:0] target;
    logic        pred_v;
    logic [63:0] pred_t;
    logic [3:0]  ras;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [3:0]  e_ras;
    logic        e_rasv;
    logic [5:0]  e_flush;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, logic r, logic [5:0] st, logic v, logic cf,
                              logic tk, logic [63:0] pc, logic [63:0] tg, logic pv,
                              logic [63:0] pt, logic [3:0] ras, logic rdy,
                              logic ev, logic [63:0] epc, logic [3:0] eras,
                              logic erv, logic [5:0] efl);
    vec_t t;
    t.name = name; t.rst = r; t.stall = st; t.valid = v; t.is_cf = cf; t.taken = tk;
    t.pc = pc; t.target = tg; t.pred_v = pv; t.pred_t = pt; t.ras = ras; t.ready = rdy;
    t.e_valid = ev; t.e_pc = epc; t.e_ras = eras; t.e_rasv = erv; t.e_flush = efl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    stall_valid     = v.stall;
    exb.ex_valid    = v.valid;
    exb.ex_is_cf    = v.is_cf;
    exb.ex_taken    = v.taken;
    exb.ex_pc       = v.pc;
    exb.ex_target   = v.target;
    exb.pred_valid  = v.pred_v;
    exb.pred_target = v.pred_t;
    ex_ras_ptr      = v.ras;
    redirect_ready  = v.ready;
  endtask

  task automatic checkOutput(input vec_t e);
    chk({e.name, ".valid"}, 64'(redirect_valid), 64'(e.e_valid));
    chk({e.name, ".pc"}, redirect_pc, e.e_pc);
    chk({e.name, ".ras"}, 64'(redirect_ras_ptr), 64'(e.e_ras));
    chk({e.name, ".rasv"}, 64'(redirect_ras_ptr_valid), 64'(e.e_rasv));
    chk({e.name, ".flush"}, 64'(flush_valid), 64'(e.e_flush));
  endtask

  localparam logic [63:0] BR  = 64'h8000_0010;
  localparam logic [63:0] TGT = 64'h8000_0000;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vcnt, pcnt, waitc;
    logic pcok;
    //                name        rst stall  v cf tk pc                     target                 pv pred_t                 ras rdy  ev  e_pc                  eras erv eflush
    vecs.push_back(mk("reset",     0, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("idle_nop",  1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("br_hit",    1, 6'h00, 1, 1, 1, BR,                    TGT,                   1, TGT,                   2,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("non_cf",    1, 6'h00, 1, 0, 1, BR,                    64'h1234,              0, TGT,                   2,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("br_nt",     1, 6'h00, 1, 1, 0, BR,                    TGT,                   1, TGT,                   2,  0,   1, 64'h8000_0014,        2,   1,  6'h07));
    vecs.push_back(mk("br_nt_ack", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  1,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("ret_mis",   1, 6'h00, 1, 1, 1, 64'h8000_0040,         64'h8000_0200,         1, 64'h8000_0100,         3,  0,   1, 64'h8000_0200,        3,   1,  6'h07));
    vecs.push_back(mk("ret_hold1", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   1, 64'h8000_0200,        3,   0,  6'h07));
    vecs.push_back(mk("ret_hold2", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   1, 64'h8000_0200,        3,   0,  6'h07));
    vecs.push_back(mk("ret_hold3", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   1, 64'h8000_0200,        3,   0,  6'h07));
    vecs.push_back(mk("ret_ack",   1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  1,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("mis_a",     1, 6'h00, 1, 1, 1, 64'h8000_0100,         64'h8000_0300,         0, 64'h0,                 5,  0,   1, 64'h8000_0300,        5,   1,  6'h07));
    vecs.push_back(mk("mis_b_ign", 1, 6'h00, 1, 1, 0, 64'h8000_0200,         64'h8000_0900,         1, 64'h8000_0900,         6,  0,   1, 64'h8000_0300,        5,   0,  6'h07));
    vecs.push_back(mk("mis_c_ack", 1, 6'h00, 1, 1, 0, 64'h8000_0204,         64'h8000_0a00,         1, 64'h8000_0a00,         7,  1,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("after_ign", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("stall_idex",1, 6'h04, 1, 1, 1, 64'h8000_0020,         64'h2000,              1, 64'h1000,              1,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("stall_oth", 1, 6'h08, 1, 1, 1, 64'h8000_0020,         64'h2000,              1, 64'h1000,              1,  0,   1, 64'h2000,             1,   1,  6'h07));
    vecs.push_back(mk("rst_redir", 0, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("no_replay", 1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("pc_wrap",   1, 6'h00, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10,              1, 64'h10,                7,  0,   1, 64'h0,                7,   1,  6'h07));
    vecs.push_back(mk("wrap_ack",  1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  1,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("tk_nopred", 1, 6'h00, 1, 1, 1, 64'h8000_0400,         64'h8000_0500,         0, 64'h8000_0500,         4,  1,   1, 64'h8000_0500,        4,   1,  6'h07));
    vecs.push_back(mk("tk_ack",    1, 6'h00, 0, 0, 0, 64'h0,                 64'h0,                 0, 64'h0,                 0,  1,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("nt_nopred", 1, 6'h00, 1, 1, 0, 64'h8000_0400,         64'h8000_0500,         0, 64'h8000_0600,         4,  0,   0, 64'h0,                0,   0,  6'h00));
    vecs.push_back(mk("ex_invld",  1, 6'h00, 0, 1, 1, 64'h8000_0400,         64'h8000_0500,         0, 64'h0,                 4,  0,   0, 64'h0,                0,   0,  6'h00));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      expq.push_back(vecs[i]);
      @(negedge clk);
      checkOutput(expq.pop_front());
    end

    // Hand sequence: redirect with ready low for two cycles. The redirect
    // must last three cycles with a single RAS restore pulse.
    applyStimulus(mk("hs", 1, 6'h00, 1, 1, 1, 64'h8000_0600, 64'h8000_0700, 0, 64'h0, 9, 0,
                     0, 64'h0, 0, 0, 6'h00));
    @(negedge clk);
    applyStimulus(mk("hs_idle", 1, 6'h00, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0,
                     0, 64'h0, 0, 0, 6'h00));
    waitc = 0;
    while (!redirect_valid && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("hs_redirect_seen", 64'(redirect_valid), 64'd1);
    vcnt = 0; pcnt = 0; pcok = 1'b1;
    for (int c = 0; c < 10 && redirect_valid; c++) begin
      vcnt++;
      pcnt += int'(redirect_ras_ptr_valid);
      if (redirect_pc !== 64'h8000_0700 || redirect_ras_ptr !== 4'd9) pcok = 1'b0;
      if (vcnt == 3) redirect_ready = 1'b1;
      @(negedge clk);
    end
    redirect_ready = 1'b0;
    chk("hs_redirect_cycles", 64'(vcnt), 64'd3);
    chk("hs_ras_pulses", 64'(pcnt), 64'd1);
    chk("hs_pc_stable", 64'(pcok), 64'd1);
    chk("hs_back_idle", 64'(redirect_valid), 64'd0);

`ifdef YSYX_041514_BPU_STATS_EN
    // Hand sequence: five branches, two of them mispredicted. The stall
    // vector stays at zero throughout.
    applyStimulus(mk("st_rst", 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("stats_reset_cf", cf_cnt, 64'd0);
    chk("stats_reset_mis", mispred_cnt, 64'd0);
    applyStimulus(mk("b1", 1, 6'h00, 1, 1, 1, BR, TGT, 1, TGT, 0, 0, 0, 0, 0, 0, 0)); @(negedge clk);
    applyStimulus(mk("b2", 1, 6'h00, 1, 1, 0, BR, TGT, 1, TGT, 0, 0, 0, 0, 0, 0, 0)); @(negedge clk);
    applyStimulus(mk("a2", 1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));      @(negedge clk);
    applyStimulus(mk("b3", 1, 6'h00, 1, 1, 0, BR, TGT, 0, TGT, 0, 0, 0, 0, 0, 0, 0)); @(negedge clk);
    applyStimulus(mk("b4", 1, 6'h00, 1, 1, 1, BR, TGT, 0, TGT, 0, 0, 0, 0, 0, 0, 0)); @(negedge clk);
    applyStimulus(mk("a4", 1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));      @(negedge clk);
    applyStimulus(mk("b5", 1, 6'h00, 1, 1, 1, BR, TGT, 1, TGT, 0, 0, 0, 0, 0, 0, 0)); @(negedge clk);
    applyStimulus(mk("end", 1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));     @(negedge clk);
    chk("stats_cf_cnt", cf_cnt, 64'd5);
    chk("stats_mispred_cnt", mispred_cnt, 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_bpu_resolve.md
YSYX_041514_BPU_RESOLVE -- requirements
Module: ysyx_041514_bpu_resolve

Interface
REQ-001 SHALL have parameter RAS_PTR_W, default $clog2(`ysyx_041514_bpu_cas_num), the width of the RAS pointer checkpoint.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-low reset (rst=0 resets on the clk edge).
REQ-004 SHALL have port stall_valid_i, input, 6 bits: per-stage stall vector.
REQ-005 SHALL have ports ex_valid_i (input, 1 bit, EX holds a valid instruction) and ex_is_cf_i (input, 1 bit, instruction is branch/jal/jalr).
REQ-006 SHALL have ports ex_taken_i (input, 1 bit, resolved taken) and ex_target_i (input, XLEN bits, resolved target).
REQ-007 SHALL have port ex_pc_i, input, XLEN bits: PC of the EX instruction.
REQ-008 SHALL have ports pred_valid_i (input, 1 bit, fetch predicted taken) and pred_target_i (input, XLEN bits, predicted target = op1+op2 carried down the pipe).
REQ-009 SHALL have port ex_ras_ptr_i, input, RAS_PTR_W bits: RAS top pointer checkpoint after this instruction's push/pop.
REQ-010 SHALL have port redirect_ready_i, input, 1 bit: the PC stage accepts the redirect.
REQ-011 SHALL have ports redirect_valid_o (output, 1 bit) and redirect_pc_o (output, XLEN bits).
REQ-012 SHALL have ports redirect_ras_ptr_o (output, RAS_PTR_W bits) and redirect_ras_ptr_valid_o (output, 1 bit), to drive the BPU RAS restore inputs.
REQ-013 SHALL have port flush_valid_o, output, 6 bits: flush request vector in CTRLBUS bit order.

Function
REQ-014 Resolve event SHALL be ex_valid_i & ex_is_cf_i & ~stall_valid_i[`ysyx_041514_CTRLBUS_ID_EX].
REQ-015 Mispredict SHALL be a resolve event with either (ex_taken_i & (~pred_valid_i | pred_target_i != ex_target_i)) or (~ex_taken_i & pred_valid_i).
REQ-016 Correct target SHALL be ex_target_i if taken, else ex_pc_i + 4 (modulo 2^XLEN).
REQ-017 FSM SHALL have states IDLE and REDIR; reset state is IDLE.
REQ-018 IDLE + mispredict SHALL go to REDIR on the next edge, registering redirect_pc_o and redirect_ras_ptr_o (latency 1 cycle).
REQ-019 In REDIR, redirect_valid_o SHALL be 1 and redirect_pc_o/redirect_ras_ptr_o SHALL remain stable until redirect_ready_i=1.
REQ-020 redirect_ras_ptr_valid_o SHALL pulse for exactly the first REDIR cycle.
REQ-021 flush_valid_o SHALL assert the PC, IF_ID and ID_EX bits in every REDIR cycle; all other bits SHALL stay 0.
REQ-022 REDIR + redirect_ready_i=1 SHALL return to IDLE on the next edge.
REQ-023 In REDIR, resolve events SHALL be ignored because they are wrong-path instructions.
REQ-024 Correct predictions and non-control-flow instructions SHALL leave all outputs at 0.

Reset
REQ-025 On rst=0 the FSM SHALL enter IDLE and all outputs SHALL be 0, including during an outstanding REDIR; no redirect is replayed after reset.

Configuration
REQ-026 With YSYX_041514_BPU_STATS_EN defined, the block SHALL add 64-bit outputs cf_cnt_o (resolve events counted in IDLE) and mispred_cnt_o (mispredicts), zeroed on reset and wrapping on overflow.
REQ-027 Without YSYX_041514_BPU_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-028 FSM state encoding and flush-mask constants SHALL live in the shared sysconfig.v definitions; XLEN and CTRLBUS indices SHALL be reused from there.
REQ-029 The target compare/next-PC logic SHALL be one sub-module, ysyx_041514_bpu_cmp; FSM and registers SHALL be in the top.

Verification
REQ-030 Branch at pc=0x80000010, pred_valid=1, target 0x80000000, taken to 0x80000000 -> no redirect, flush=0.
REQ-031 Same branch not taken -> next cycle redirect_valid=1, pc=0x80000014, flush PC/IF_ID/ID_EX set, ras_ptr_valid pulses once.
REQ-032 ret with pred_target 0x80000100, actual 0x80000200, ras_ptr=3, redirect_ready low 3 cycles -> redirect held 4 cycles at 0x80000200, ras_ptr_o=3, ras_ptr_valid only in the first cycle.
REQ-033 Mispredict in REDIR with a second mispredict in the next cycle -> second ignored; redirect_pc unchanged.
REQ-034 rst=0 asserted mid-REDIR -> next cycle all outputs 0, state IDLE.
REQ-035 With stats enabled: 5 branches, 2 mispredicted, no overlap -> cf_cnt_o=5, mispred_cnt_o=2.
